pl_hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32 core. Drives stall/flush of the IF/ID, ID/EX, EX/MEM
//  and MEM/WB registers and EX-stage forwarding selects. Sequences data-memory accesses in MEM via a
//  req/ready handshake, freezing the pipe on a slow memory. Sits beside the pipeline registers.

---
 rtl/pl_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pl_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_hazard_ctrl.sv
// rtl/pl_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and data-memory handshake controller
module pl_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addrd,
    input  logic [4:0]       rs2_addrd,
    input  logic [4:0]       rs1_addre,
    input  logic [4:0]       rs2_addre,
    input  logic [4:0]       wr_addre,
    input  logic [1:0]       result_sgne,
    input  logic [4:0]       wr_addrm,
    input  logic             regwr_sgnm,
    input  logic [1:0]       result_sgnm,
    input  logic             memwr_sgnm,
    input  logic [4:0]       wr_addrw,
    input  logic             regwr_sgnw,
    input  logic             pcsrce,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             stallf,
    output logic             stalld,
    output logic             stalle,
    output logic             stallm,
    output logic             flushd,
    output logic             flushe,
    output logic             flushw,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic mem_acc;
    logic req;
    logic timeout_now;
    logic mem_stall;
    logic lw_stall;

    // A later stage writing a non-zero rd that the EX operand reads; MEM wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (regwr_sgnm && (wr_addrm != 5'd0) && (wr_addrm == rs)) begin
            return 2'b10;
        end else if (regwr_sgnw && (wr_addrw != 5'd0) && (wr_addrw == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign mem_acc = memwr_sgnm | (result_sgnm == 2'b01);

    // Memory access sequencer: next state, wait counter, timeout and request.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        req         = 1'b0;
        timeout_now = 1'b0;
        case (state_q)
            IDLE: begin
                req = mem_acc;
                if (mem_acc && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                req = 1'b1;
                if (dmem_ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abandon the access; the pipe moves on as if it completed.
                    timeout_now = 1'b1;
                    state_d     = IDLE;
                    wait_cnt_d  = '0;
                    mem_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stall/flush/forward decode; a memory stall freezes everything and bubbles WB.
    always_comb begin
        mem_stall  = req & ~dmem_ready & ~timeout_now;
        lw_stall   = (result_sgne == 2'b01) && (wr_addre != 5'd0) &&
                     ((wr_addre == rs1_addrd) || (wr_addre == rs2_addrd));
        dmem_req   = ~rst & req;
        stallf     = ~rst & (mem_stall | lw_stall);
        stalld     = ~rst & (mem_stall | lw_stall);
        stalle     = ~rst & mem_stall;
        stallm     = ~rst & mem_stall;
        flushw     = ~rst & mem_stall;
        flushe     = ~rst & ~mem_stall & (lw_stall | pcsrce);
        flushd     = ~rst & ~mem_stall & pcsrce;
        forward_ae = rst ? 2'b00 : fwd_sel(rs1_addre);
        forward_be = rst ? 2'b00 : fwd_sel(rs2_addre);
    end

    // Saturating count of cycles the front end was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallf && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, counters and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// tb/tb_pl_hazard_ctrl.sv - self-checking bench for pl_hazard_ctrl
module tb_pl_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_addrd, rs2_addrd, rs1_addre, rs2_addre, wr_addre, wr_addrm, wr_addrw;
    logic [1:0] result_sgne, result_sgnm;
    logic regwr_sgnm, memwr_sgnm, regwr_sgnw, pcsrce, dmem_ready;
    logic dmem_req, stallf, stalld, stalle, stallm, flushd, flushe, flushw, mem_err;
    logic [1:0] forward_ae, forward_be;
    logic [CW-1:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    pl_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_addrd(rs1_addrd), .rs2_addrd(rs2_addrd),
        .rs1_addre(rs1_addre), .rs2_addre(rs2_addre),
        .wr_addre(wr_addre), .result_sgne(result_sgne),
        .wr_addrm(wr_addrm), .regwr_sgnm(regwr_sgnm),
        .result_sgnm(result_sgnm), .memwr_sgnm(memwr_sgnm),
        .wr_addrw(wr_addrw), .regwr_sgnw(regwr_sgnw),
        .pcsrce(pcsrce), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .stallf(stallf), .stalld(stalld),
        .stalle(stalle), .stallm(stallm), .flushd(flushd),
        .flushe(flushe), .flushw(flushw),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model state: how many cycles the current access has already been pending,
    // sticky error flag and the stall counter as plain integers.
    int m_age = 0;
    bit m_err = 1'b0;
    int m_cnt = 0;
    bit s_req, s_done, s_to, s_stallf;

    bit e_acc, e_req, e_to, e_ms, e_lw;
    logic [1:0] e_fa, e_fb;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (regwr_sgnm && wr_addrm != 0 && wr_addrm == rs) return 2'b10;
        if (regwr_sgnw && wr_addrw != 0 && wr_addrw == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            s_req = 0; s_done = 0; s_to = 0; s_stallf = 0;
            chk("rst_dmem_req", dmem_req, 0);
            chk("rst_stallf", stallf, 0);
            chk("rst_stalld", stalld, 0);
            chk("rst_stalle", stalle, 0);
            chk("rst_stallm", stallm, 0);
            chk("rst_flushd", flushd, 0);
            chk("rst_flushe", flushe, 0);
            chk("rst_flushw", flushw, 0);
            chk("rst_fwd_a", forward_ae, 0);
            chk("rst_fwd_b", forward_be, 0);
            chk("rst_mem_err", mem_err, 0);
            chk("rst_stall_cycles", stall_cycles, 0);
        end else begin
            e_acc = memwr_sgnm || (result_sgnm == 2'b01);
            e_req = e_acc || (m_age > 0);
            e_to  = e_req && !dmem_ready && (m_age == TO - 1);
            e_ms  = e_req && !dmem_ready && !e_to;
            e_lw  = (result_sgne == 2'b01) && wr_addre != 0 &&
                    (wr_addre == rs1_addrd || wr_addre == rs2_addrd);
            e_fa  = m_fwd(rs1_addre);
            e_fb  = m_fwd(rs2_addre);
            chk("m_dmem_req", dmem_req, e_req);
            chk("m_stallf", stallf, e_ms || e_lw);
            chk("m_stalld", stalld, e_ms || e_lw);
            chk("m_stalle", stalle, e_ms);
            chk("m_stallm", stallm, e_ms);
            chk("m_flushw", flushw, e_ms);
            chk("m_flushd", flushd, !e_ms && pcsrce);
            chk("m_flushe", flushe, !e_ms && (pcsrce || e_lw));
            chk("m_fwd_a", forward_ae, e_fa);
            chk("m_fwd_b", forward_be, e_fb);
            chk("m_mem_err", mem_err, m_err);
            chk("m_stall_cycles", stall_cycles, m_cnt);
            s_req    = e_req;
            s_done   = dmem_ready || e_to;
            s_to     = e_to;
            s_stallf = e_ms || e_lw;
        end
    end

    // Advance the model on the clock edge using the values judged at the preceding negedge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age = 0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            if (s_req) begin
                if (s_done) begin
                    m_age = 0;
                    if (s_to) m_err = 1'b1;
                end else begin
                    m_age++;
                end
            end
            if (s_stallf && m_cnt < CMAX) m_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs1_addrd = 0; rs2_addrd = 0; rs1_addre = 0; rs2_addre = 0;
        wr_addre = 0; wr_addrm = 0; wr_addrw = 0;
        result_sgne = 0; result_sgnm = 0;
        regwr_sgnm = 0; memwr_sgnm = 0; regwr_sgnw = 0;
        pcsrce = 0; dmem_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr();
        pcsrce = 1'b1;
        #1;
        chk("reset_flushd", flushd, 0);
        chk("reset_stallf", stallf, 0);
        chk("reset_mem_err", mem_err, 0);
        chk("reset_cnt", stall_cycles, 0);
        tick();
        rst = 1'b0;
        clr();

        // Forwarding priority and x0
        rs1_addre = 5; wr_addrm = 5; regwr_sgnm = 1; wr_addrw = 5; regwr_sgnw = 1;
        #1 chk("fwd_mem", forward_ae, 2'b10);
        regwr_sgnm = 0;
        #1 chk("fwd_wb", forward_ae, 2'b01);
        wr_addrw = 0;
        #1 chk("fwd_x0", forward_ae, 2'b00);
        rs2_addre = 9; wr_addrm = 9; regwr_sgnm = 1;
        #1 chk("fwd_b_mem", forward_be, 2'b10);
        tick();
        clr();

        // Load-use stall, one cycle
        result_sgne = 2'b01; wr_addre = 7; rs2_addrd = 7;
        #1;
        chk("lw_stallf", stallf, 1);
        chk("lw_stalld", stalld, 1);
        chk("lw_flushe", flushe, 1);
        chk("lw_stalle", stalle, 0);
        tick();
        chk("lw_cnt", stall_cycles, 1);
        clr();
        #1 chk("lw_clear", stallf, 0);
        result_sgne = 2'b01; wr_addre = 0; rs1_addrd = 0;
        #1 chk("lw_x0", stallf, 0);
        tick();
        clr();

        // Taken branch, alone and with a load-use hazard
        pcsrce = 1;
        #1;
        chk("br_flushd", flushd, 1);
        chk("br_flushe", flushe, 1);
        chk("br_stallf", stallf, 0);
        tick();
        chk("br_cnt", stall_cycles, 1);
        result_sgne = 2'b01; wr_addre = 3; rs1_addrd = 3;
        #1;
        chk("brlw_flushd", flushd, 1);
        chk("brlw_stallf", stallf, 1);
        tick();
        chk("brlw_cnt", stall_cycles, 2);
        clr();

        // Store with a slow memory: 3 wait cycles, branch held off by the freeze
        memwr_sgnm = 1; pcsrce = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_req", dmem_req, 1);
            chk("st_stallm", stallm, 1);
            chk("st_flushw", flushw, 1);
            chk("st_flushd", flushd, 0);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk("st_done_req", dmem_req, 1);
        chk("st_done_stallf", stallf, 0);
        chk("st_done_flushd", flushd, 1);
        tick();
        chk("st_cnt", stall_cycles, 5);
        pcsrce = 0;
        #1;
        chk("b2b_req", dmem_req, 1);
        chk("b2b_stallf", stallf, 0);
        tick();
        clr();
        #1 chk("idle_req", dmem_req, 0);

        // Load that times out
        result_sgnm = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1 chk("to_stallf", stallf, 1);
            tick();
        end
        #1;
        chk("to_release", stallf, 0);
        chk("to_req", dmem_req, 1);
        tick();
        clr();
        #1;
        chk("to_err", mem_err, 1);
        chk("to_cnt", stall_cycles, 8);
        memwr_sgnm = 1; dmem_ready = 1;
        #1 chk("after_to_stallf", stallf, 0);
        tick();
        clr();
        #1 chk("err_sticky", mem_err, 1);

        // Counter saturation
        result_sgne = 2'b01; wr_addre = 4; rs1_addrd = 4;
        repeat (9) tick();
        chk("sat_cnt", stall_cycles, CMAX);
        chk("sat_stallf", stallf, 1);
        tick();
        chk("sat_hold", stall_cycles, CMAX);
        clr();

        // Async reset in the middle of a wait
        memwr_sgnm = 1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_req", dmem_req, 0);
        chk("arst_stallf", stallf, 0);
        chk("arst_flushw", flushw, 0);
        chk("arst_err", mem_err, 0);
        chk("arst_cnt", stall_cycles, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_stallf", stallf, 1);
        chk("post_rst_req", dmem_req, 1);
        tick();
        dmem_ready = 1;
        #1 chk("post_rst_done", stallf, 0);
        tick();
        clr();
        #1;
        chk("post_rst_cnt", stall_cycles, 1);
        chk("post_rst_err", mem_err, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
